// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix operand server and its banks.
package matrix_pkg;

  // Index width of the engine's operand and result index ports.
  localparam int IW = 5;

  // IEEE-754 single-precision constants.
  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_ZERO = 32'h00000000;

  // Top-level run sequencing.
  typedef enum logic [1:0] {
    T_LOAD  = 2'd0,
    T_READY = 2'd1,
    T_RUN   = 2'd2,
    T_DONE  = 2'd3
  } top_state_t;

  // Result-sink handshake sequencing.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACK      = 2'd1,
    S_WAIT_LOW = 2'd2
  } sink_state_t;

endpackage

// File: rtl/matrix_bank.sv
// M x M word store addressed by (row, col): one synchronous write port,
// one registered read port, bulk clear. Out-of-range indices write nothing
// and read as zero.
module matrix_bank
  import matrix_pkg::*;
#(
  parameter int M = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [IW-1:0] wr_i,
  input  logic [IW-1:0] wr_j,
  input  logic [31:0]   wr_data,
  input  logic [IW-1:0] rd_i,
  input  logic [IW-1:0] rd_j,
  output logic [31:0]   rd_data
);

  localparam int N  = M * M;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [31:0] mem_q [N];
  logic [31:0] rd_data_q;

  function automatic logic in_range(input logic [IW-1:0] i, input logic [IW-1:0] j);
    return (32'(i) < 32'(M)) && (32'(j) < 32'(M));
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] i, input logic [IW-1:0] j);
    return AW'(32'(i) * 32'(M) + 32'(j));
  endfunction

  // Storage: reset and clear zero every word; in-range writes land row-major.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < N; k++) mem_q[k] <= FP_ZERO;
    end else if (we && in_range(wr_i, wr_j)) begin
      mem_q[addr_of(wr_i, wr_j)] <= wr_data;
    end
  end

  // Registered read with a zero answer for indices outside the matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= FP_ZERO;
    end else if (in_range(rd_i, rd_j)) begin
      rd_data_q <= mem_q[addr_of(rd_i, rd_j)];
    end else begin
      rd_data_q <= FP_ZERO;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/matrix_operand_server.sv
// Memory-side responder for a sequential matrix multiplier: loads A and B,
// serves operands by index, sinks the result stream into C and exposes C.
//
// Handshakes: a load word transfers on a cycle where load_valid & load_ready
// are both high; load_ready does not depend on load_valid. A result transfers
// when z_stb is seen in S_IDLE during RUN; z_ack answers one cycle later for
// exactly one cycle, and the next transfer needs z_stb to drop first.
module matrix_operand_server
  import matrix_pkg::*;
#(
  parameter int m = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic          load_sel,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  input  logic          go,
  output logic          start,
  input  logic          mult_done,
  input  logic [IW-1:0] a_i,
  input  logic [IW-1:0] a_j,
  input  logic [IW-1:0] b_i,
  input  logic [IW-1:0] b_j,
  output logic [31:0]   a_in,
  output logic [31:0]   b_in,
  input  logic [31:0]   z_out,
  input  logic [IW-1:0] z_i,
  input  logic [IW-1:0] z_j,
  input  logic          z_stb,
  output logic          z_ack,
  input  logic [IW-1:0] rd_i,
  input  logic [IW-1:0] rd_j,
  output logic [31:0]   rd_data,
  output logic          results_valid,
  output logic          err,
  output top_state_t    dbg_top_state_o,
  output sink_state_t   dbg_sink_state_o
);

  localparam int MM  = m * m;
  localparam int MMM = m * m * m;
  localparam int CW  = $clog2(MM + 1);

  top_state_t    top_q, top_d;
  sink_state_t   sink_q, sink_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [31:0]   zcnt_q, zcnt_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic          clr_c;

  logic          sel_full, load_acc, z_take, z_in_range, op_oob;
  logic [CW-1:0] ld_cnt;
  logic [IW-1:0] ld_row, ld_col;

  assign sel_full   = load_sel ? (cnt_b_q == CW'(MM)) : (cnt_a_q == CW'(MM));
  assign load_ready = !rst && (top_q == T_LOAD) && !sel_full;
  assign load_acc   = load_valid && load_ready;
  assign z_take     = !rst && (sink_q == S_IDLE) && z_stb && (top_q == T_RUN);
  assign z_in_range = (z_i < IW'(m)) && (z_j < IW'(m));
  assign op_oob     = (a_i >= IW'(m)) || (a_j >= IW'(m)) ||
                      (b_i >= IW'(m)) || (b_j >= IW'(m));

  // The load counter of the selected matrix doubles as its row-major address.
  assign ld_cnt = load_sel ? cnt_b_q : cnt_a_q;
  assign ld_row = IW'(32'(ld_cnt) / 32'(m));
  assign ld_col = IW'(32'(ld_cnt) % 32'(m));

  // Top sequencing, load counters, run bookkeeping and sticky error.
  always_comb begin
    top_d   = top_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    zcnt_d  = zcnt_q + 32'(z_take);
    start_d = 1'b0;
    err_d   = err_q;
    clr_c   = 1'b0;
    case (top_q)
      T_LOAD: begin
        if (load_acc) begin
          if (load_sel) cnt_b_d = cnt_b_q + CW'(1);
          else          cnt_a_d = cnt_a_q + CW'(1);
        end
        if (cnt_a_q == CW'(MM) && cnt_b_q == CW'(MM)) top_d = T_READY;
      end
      T_READY: begin
        if (go) begin
          start_d = 1'b1;
          clr_c   = 1'b1;
          zcnt_d  = '0;
          top_d   = T_RUN;
        end
      end
      T_RUN: begin
        // A strobe taken in the same cycle as mult_done still counts.
        if (mult_done) begin
          top_d = T_DONE;
          if (zcnt_d != 32'(MMM)) err_d = 1'b1;
        end
      end
      T_DONE: begin
        if (go) begin
          start_d = 1'b1;
          clr_c   = 1'b1;
          zcnt_d  = '0;
          top_d   = T_RUN;
        end else if (load_valid) begin
          cnt_a_d = '0;
          cnt_b_d = '0;
          top_d   = T_LOAD;
        end
      end
      default: top_d = T_LOAD;
    endcase
    if (op_oob) err_d = 1'b1;
    if (z_take && !z_in_range) err_d = 1'b1;
    if ((sink_q == S_IDLE) && z_stb && (top_q != T_RUN)) err_d = 1'b1;
  end

  // Result sink: one write and one single-cycle ack per strobe edge.
  always_comb begin
    sink_d = sink_q;
    case (sink_q)
      S_IDLE:     if (z_take) sink_d = S_ACK;
      S_ACK:      sink_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!z_stb) sink_d = S_IDLE;
      default:    sink_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any run or handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= T_LOAD;
      sink_q  <= S_IDLE;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      zcnt_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      sink_q  <= sink_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      zcnt_q  <= zcnt_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  matrix_bank #(.M(m)) u_bank_a (
    .clk(clk), .rst(rst), .clr(1'b0),
    .we(load_acc && !load_sel), .wr_i(ld_row), .wr_j(ld_col), .wr_data(load_data),
    .rd_i(a_i), .rd_j(a_j), .rd_data(a_in)
  );

  matrix_bank #(.M(m)) u_bank_b (
    .clk(clk), .rst(rst), .clr(1'b0),
    .we(load_acc && load_sel), .wr_i(ld_row), .wr_j(ld_col), .wr_data(load_data),
    .rd_i(b_i), .rd_j(b_j), .rd_data(b_in)
  );

  matrix_bank #(.M(m)) u_bank_c (
    .clk(clk), .rst(rst), .clr(clr_c),
    .we(z_take), .wr_i(z_i), .wr_j(z_j), .wr_data(z_out),
    .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_data)
  );

  assign start            = start_q;
  assign z_ack            = (sink_q == S_ACK);
  assign results_valid    = (top_q == T_DONE);
  assign err              = err_q;
  assign dbg_top_state_o  = top_q;
  assign dbg_sink_state_o = sink_q;

endmodule

// File: doc/matrix_operand_server.md
Name: matrix_operand_server

Overview:
- Memory-side responder for sequential_matrix_multiplier-style engines (m x m, IEEE-754 single words).
- Holds operand matrices A and B, loaded row-major over a valid/ready port.
- Serves a_in/b_in from the engine's a_i/a_j/b_i/b_j indices.
- Sinks the engine's z_out/z_i/z_j/z_stb stream with a z_ack handshake, stores C, and exposes C on a read port once the run finishes.

Parameters:
- m, 4, matrix dimension; legal range 1..31.
- IW, 5, index width. Fixed to match the engine's index ports.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_valid  in  1  load word present
- load_sel  in  1  0 = A, 1 = B
- load_data  in  32  operand word, row-major
- load_ready  out  1  load word accepted this cycle
- go  in  1  request a multiply run
- start  out  1  one-cycle pulse to the engine's start input
- mult_done  in  1  engine's done pulse
- a_i, a_j, b_i, b_j  in  5 each  operand indices from the engine
- a_in, b_in  out  32 each  A[a_i][a_j], B[b_i][b_j]
- z_out  in  32  engine result word
- z_i, z_j  in  5 each  result indices
- z_stb  in  1  result strobe
- z_ack  out  1  result acknowledge
- rd_i, rd_j  in  5 each  C read index
- rd_data  out  32  C[rd_i][rd_j]
- results_valid  out  1  C complete
- err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0; A, B, C cleared to 0; load counters 0; top FSM in LOAD; sink FSM in S_IDLE.
- Synchronous reset applies mid-run too. In-flight handshakes are abandoned and z_ack drops the next cycle.
- Top FSM:
  - LOAD: load_ready = 1 only while the selected matrix has fewer than m*m words. An accepted word (load_valid & load_ready) is written at the per-matrix counter, row-major, then the counter increments. When both counters reach m*m, go to READY.
  - READY: when go = 1, pulse start for exactly 1 cycle, clear C and the z count, go to RUN.
  - RUN: when mult_done = 1, go to DONE. If z count != m*m*m at that point, set err.
  - DONE: results_valid = 1. go = 1 re-pulses start and returns to RUN (operands retained). load_valid = 1 with load_sel clears both counters and returns to LOAD; that word is accepted the following cycle.
- Loads are never accepted outside LOAD. go in LOAD is ignored.
- A full matrix holds load_ready = 0 for that select; no wrap-around.
- Operand read:
  - a_in and b_in are registered, 1-cycle latency from the indices.
  - Either index >= m returns 0 and sets err.
- Result sink FSM (active in RUN only):
  - S_IDLE: z_stb = 1 → write z_out to C[z_i][z_j] (last write wins, so partial sums are overwritten by the final k), increment z count, go to S_ACK.
  - S_ACK: z_ack = 1 for exactly 1 cycle → S_WAIT_LOW.
  - S_WAIT_LOW: wait for z_stb = 0 → S_IDLE. Every strobe therefore yields exactly one write and one ack.
  - z_i or z_j >= m: write dropped, ack still given, err set.
  - z_stb outside RUN: no write, no ack, err set.
- Simultaneous mult_done and z_stb: the write completes and ack is still issued, then the top FSM enters DONE.
- rd_data is registered, 1-cycle latency, valid in any state. Out-of-range index reads 0.
- err clears only on rst.

Decomposition:
- Shared package matrix_pkg:
  - top and sink state encodings;
  - IW = 5;
  - FP constants FP_ONE = 32'h3F800000 and FP_ZERO = 32'h00000000.
- Sub-module matrix_bank, instantiated three times for A, B and C:
  - m*m x 32 register array, synchronous write, registered read;
  - clear input;
  - returns 0 on out-of-range index.

Test Plan:
- Load A = identity (FP_ONE on the diagonal) and B[i][j] = float(4i+j); check load_ready drops after 16 words per matrix. Drive a_i = 2, a_j = 2, b_i = 1, b_j = 3 → one cycle later a_in = 32'h3F800000 and b_in = 32'h40E00000 (7.0).
- go in READY → start high for exactly 1 cycle. A second go during RUN → no start.
- Bench engine model issues 64 z strobes, holding z_stb until z_ack → exactly one z_ack per strobe, each 1 cycle wide. After mult_done, results_valid = 1, rd_i = 3, rd_j = 0 gives 32'h41400000 (12.0), err = 0.
- z_stb held high for 5 cycles after ack → no second write or ack until z_stb goes low and rises again.
- z_i = 7 strobe → ack given, C unchanged, err = 1. mult_done after only 63 strobes → err = 1.
- rst asserted while z_ack is high in RUN → next cycle z_ack = 0, FSM in LOAD, A, B and C read 0, load_ready = 1.
